// File: rtl/oled_pixel_streamer.sv
// Scans a WIDTH x HEIGHT frame through pixel_index and streams each RGB565 word MSB-first over SPI mode 0.
// Define OLED_WINDOW_CMD_EN to open every frame with the column/row window command bytes.
module oled_pixel_streamer #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter int CLK_DIV     = 2,
    parameter int PIX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] pixel_data,
    output logic [12:0] pixel_index,
    output logic        frame_begin,
    output logic        frame_done,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        dc
);
    localparam logic [12:0] LAST_PIX = 13'(WIDTH * HEIGHT - 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(2 * CLK_DIV + 1);
    localparam int FET_W = $clog2(PIX_LATENCY + 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);
    localparam logic [FET_W-1:0] FET_LAST = FET_W'(PIX_LATENCY);

    typedef enum logic [2:0] {IDLE, CMD, FETCH, SHIFT, GAP} state_t;

    state_t           state;
    logic [15:0]      shreg;
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [FET_W-1:0] fet_cnt;
    logic             half_end;

    // last clk cycle of the current sclk half-period
    assign half_end = (div_cnt == DIV_LAST);

`ifdef OLED_WINDOW_CMD_EN
    logic [2:0] cmd_idx;
    logic [7:0] cmd_cur;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = 8'h15;
            3'd1:    cmd_byte = 8'h00;
            3'd2:    cmd_byte = 8'(WIDTH - 1);
            3'd3:    cmd_byte = 8'h75;
            3'd4:    cmd_byte = 8'h00;
            default: cmd_byte = 8'(HEIGHT - 1);
        endcase
    endfunction

    // byte to load next: the first one when leaving IDLE, otherwise the successor
    assign cmd_cur = cmd_byte((state == IDLE) ? 3'd0 : cmd_idx + 3'd1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cs_n        <= 1'b1;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            dc          <= 1'b0;
            pixel_index <= '0;
            frame_begin <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            gap_cnt     <= '0;
            fet_cnt     <= '0;
`ifdef OLED_WINDOW_CMD_EN
            cmd_idx     <= '0;
`endif
        end else begin
            frame_begin <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        cs_n        <= 1'b0;
                        frame_begin <= 1'b1;
                        busy        <= 1'b1;
                        pixel_index <= '0;
                        sclk        <= 1'b0;
                        div_cnt     <= '0;
`ifdef OLED_WINDOW_CMD_EN
                        state       <= CMD;
                        dc          <= 1'b0;
                        cmd_idx     <= '0;
                        shreg       <= {8'h00, cmd_cur};
                        bit_cnt     <= 4'd7;
                        mosi        <= cmd_cur[7];
`else
                        state       <= FETCH;
                        dc          <= 1'b1;
                        fet_cnt     <= '0;
`endif
                    end
                end
                FETCH: begin
                    // colour for pixel_index arrives PIX_LATENCY cycles after the index changed
                    if (fet_cnt == FET_LAST) begin
                        shreg   <= pixel_data;
                        mosi    <= pixel_data[15];
                        bit_cnt <= 4'd15;
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        fet_cnt <= fet_cnt + 1'b1;
                    end
                end
                CMD, SHIFT: begin
                    div_cnt <= half_end ? '0 : div_cnt + 1'b1;
                    if (half_end) sclk <= ~sclk;
                    // falling sclk edge: present the next bit or finish the current unit
                    if (half_end && sclk) begin
                        if (bit_cnt != 4'd0) begin
                            bit_cnt <= bit_cnt - 4'd1;
                            mosi    <= shreg[bit_cnt - 4'd1];
                        end
`ifdef OLED_WINDOW_CMD_EN
                        else if (state == CMD) begin
                            if (cmd_idx == 3'd5) begin
                                state   <= FETCH;
                                dc      <= 1'b1;
                                fet_cnt <= '0;
                            end else begin
                                cmd_idx <= cmd_idx + 3'd1;
                                shreg   <= {8'h00, cmd_cur};
                                bit_cnt <= 4'd7;
                                mosi    <= cmd_cur[7];
                            end
                        end
`endif
                        else if (pixel_index != LAST_PIX) begin
                            pixel_index <= pixel_index + 13'd1;
                            fet_cnt     <= '0;
                            state       <= FETCH;
                        end else begin
                            frame_done <= 1'b1;
                            cs_n       <= 1'b1;
                            mosi       <= 1'b0;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer: two small-frame instances, SPI decoded back into bytes/words and
// compared against an index-order frame model every cycle; directed scenarios for idle, back-to-back, enable drop and reset abort.
module tb_oled_pixel_streamer;
    localparam int W0 = 8, H0 = 4, CD0 = 2, PL0 = 1;
    localparam int W1 = 4, H1 = 2, CD1 = 1, PL1 = 1;
`ifdef OLED_WINDOW_CMD_EN
    localparam int NCMD = 6;
`else
    localparam int NCMD = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       en;
    logic [15:0]      pdata0, pdata1;
    logic [1:0][12:0] pidx;
    logic [1:0]       fb, fd, busy, cs_n, sclk, mosi, dc;

    int vectors = 0;
    int miscompares = 0;

    oled_pixel_streamer #(.WIDTH(W0), .HEIGHT(H0), .CLK_DIV(CD0), .PIX_LATENCY(PL0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .pixel_data(pdata0), .pixel_index(pidx[0]),
        .frame_begin(fb[0]), .frame_done(fd[0]), .busy(busy[0]), .cs_n(cs_n[0]),
        .sclk(sclk[0]), .mosi(mosi[0]), .dc(dc[0]));

    oled_pixel_streamer #(.WIDTH(W1), .HEIGHT(H1), .CLK_DIV(CD1), .PIX_LATENCY(PL1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .pixel_data(pdata1), .pixel_index(pidx[1]),
        .frame_begin(fb[1]), .frame_done(fd[1]), .busy(busy[1]), .cs_n(cs_n[1]),
        .sclk(sclk[1]), .mosi(mosi[1]), .dc(dc[1]));

    // colour source with one register stage echoing the requested index
    always @(posedge clk) pdata0 <= {3'b000, pidx[0]};
    assign pdata1 = 16'hF800;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cdiv(input int i);
        return (i == 0) ? CD0 : CD1;
    endfunction
    function automatic int plat(input int i);
        return (i == 0) ? PL0 : PL1;
    endfunction
    function automatic int npix(input int i);
        return (i == 0) ? W0 * H0 : W1 * H1;
    endfunction
    function automatic logic [7:0] exp_cmd(input int i, input int k);
        int w, h;
        w = (i == 0) ? W0 : W1;
        h = (i == 0) ? H0 : H1;
        case (k)
            0: return 8'h15;
            1: return 8'h00;
            2: return 8'(w - 1);
            3: return 8'h75;
            4: return 8'h00;
            default: return 8'(h - 1);
        endcase
    endfunction
    // frame model: dut0 sees its own pixel number, dut1 a constant red
    function automatic logic [15:0] exp_word(input int i, input int k);
        return (i == 0) ? 16'(k) : 16'hF800;
    endfunction

    int          nbits[2], words_seen[2], cmds_seen[2], lo_run[2], hi_run[2], gap[2];
    int          fb_cnt[2] = '{0, 0};
    int          fd_cnt[2] = '{0, 0};
    int          rises[2]  = '{0, 0};
    logic [15:0] acc[2];
    logic        cur_dc[2], p_sclk[2], p_mosi[2], p_cs[2], p_busy[2], p_fd[2];
    logic [7:0]  cmd_log[6];
    logic [15:0] first_word0, last_word[2];

    always @(negedge clk) begin
        logic rise, fall;
        int   exp_lo;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                nbits[i] = 0; words_seen[i] = 0; cmds_seen[i] = 0;
                lo_run[i] = 0; hi_run[i] = 0; gap[i] = 0; acc[i] = '0; cur_dc[i] = 1'b0;
                p_sclk[i] = 1'b0; p_mosi[i] = 1'b0; p_cs[i] = 1'b1; p_busy[i] = 1'b0; p_fd[i] = 1'b0;
            end else begin
                rise = !p_sclk[i] && sclk[i];
                fall = p_sclk[i] && !sclk[i];
                chk("pix_range", 32'(pidx[i] <= 13'(npix(i) - 1)), 1);
                if (cs_n[i]) chk("sclk_idle", 32'(sclk[i]), 0);
                if (fb[i]) begin
                    fb_cnt[i]++;
                    chk("fb_cs_fall", 32'({p_cs[i], cs_n[i]}), 32'b10);
                    chk("fb_idx", 32'(pidx[i]), 0);
                    words_seen[i] = 0; cmds_seen[i] = 0; nbits[i] = 0; lo_run[i] = 0;
                end
                if (sclk[i]) begin
                    chk("mosi_hold", 32'(mosi[i]), 32'(p_mosi[i]));
                    hi_run[i]++;
                end
                if (rise) begin
                    rises[i]++;
                    chk("rise_cs", 32'(cs_n[i]), 0);
                    exp_lo = (nbits[i] == 0 && dc[i]) ? plat(i) + 1 + cdiv(i) : cdiv(i);
                    chk("lo_run", lo_run[i], exp_lo);
                    lo_run[i] = 0;
                    if (nbits[i] == 0) begin
                        cur_dc[i] = dc[i];
                        if (dc[i] && words_seen[i] == 0) chk("cmds_before_data", cmds_seen[i], NCMD);
                    end else begin
                        chk("dc_stable", 32'(dc[i]), 32'(cur_dc[i]));
                    end
                    acc[i] = {acc[i][14:0], mosi[i]};
                    nbits[i]++;
                    if (!cur_dc[i] && nbits[i] == 8) begin
                        chk("cmd_byte", 32'(acc[i][7:0]), 32'(exp_cmd(i, cmds_seen[i])));
                        if (i == 0 && fb_cnt[0] == 1 && cmds_seen[0] < 6) cmd_log[cmds_seen[0]] = acc[0][7:0];
                        cmds_seen[i]++;
                        nbits[i] = 0;
                    end else if (cur_dc[i] && nbits[i] == 16) begin
                        chk("pix_word", 32'(acc[i]), 32'(exp_word(i, words_seen[i])));
                        if (i == 0 && fb_cnt[0] == 1 && words_seen[0] == 0) first_word0 = acc[0];
                        if (i == 1 || fb_cnt[0] == 1) last_word[i] = acc[i];
                        words_seen[i]++;
                        nbits[i] = 0;
                    end
                end else if (!sclk[i] && !cs_n[i]) begin
                    lo_run[i]++;
                end
                if (fall) begin
                    chk("hi_run", hi_run[i], cdiv(i));
                    hi_run[i] = 0;
                end
                if (fd[i]) begin
                    fd_cnt[i]++;
                    chk("fd_words", words_seen[i], npix(i));
                    chk("fd_nbits", nbits[i], 0);
                    chk("fd_cs", 32'(cs_n[i]), 1);
                    chk("fd_pulse", 32'(p_fd[i]), 0);
                    gap[i] = 0;
                end
                if (cs_n[i] && busy[i]) gap[i]++;
                if (p_busy[i] && !busy[i]) chk("gap_len", gap[i], 2 * cdiv(i));
                p_sclk[i] = sclk[i]; p_mosi[i] = mosi[i]; p_cs[i] = cs_n[i];
                p_busy[i] = busy[i]; p_fd[i] = fd[i];
            end
        end
    end

    task automatic wait_ev(input int i, input bit want_fd, input int budget, output int n);
        for (n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (want_fd ? fd[i] : fb[i]) break;
        end
        #1;
        if (n > budget) chk(want_fd ? "timeout_fd" : "timeout_fb", 0, 1);
    endtask

    task automatic wait_pix0(input int idx, input bit need_sclk, input int budget);
        int n;
        for (n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (pidx[0] == 13'(idx) && (!need_sclk || sclk[0])) break;
        end
        if (n > budget) chk("timeout_pix", 0, 1);
    endtask

    initial begin
        int n;
`ifdef OLED_WINDOW_CMD_EN
        logic [7:0] lit_cmd[6];
        lit_cmd = '{8'h15, 8'h00, 8'h07, 8'h75, 8'h00, 8'h03};
`endif
        rst_n = 1'b0;
        en    = 2'b00;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // idle with enable low
        repeat (1000) @(negedge clk);
        #1;
        chk("idle_rises", rises[0], 0);
        chk("idle_cs", 32'(cs_n[0]), 1);
        chk("idle_sclk", 32'(sclk[0]), 0);
        chk("idle_mosi", 32'(mosi[0]), 0);
        chk("idle_busy", 32'(busy[0]), 0);
        chk("idle_idx", 32'(pidx[0]), 0);
        chk("idle_fb", fb_cnt[0], 0);

        // first frame, enable kept high
        en[0] = 1'b1;
        wait_ev(0, 1'b0, 10, n);
        chk("fb_latency", n, 1);
        wait_ev(0, 1'b1, 6000, n);
        chk("fd_count1", fd_cnt[0], 1);
        chk("fb_count1", fb_cnt[0], 1);
        chk("lit_first_word", 32'(first_word0), 32'h0000);
        chk("lit_last_word", 32'(last_word[0]), 32'h001F);
`ifdef OLED_WINDOW_CMD_EN
        for (int k = 0; k < 6; k++) chk("lit_cmd", 32'(cmd_log[k]), 32'(lit_cmd[k]));
`endif

        // back-to-back frame, enable dropped mid-frame
        wait_ev(0, 1'b0, 20, n);
        chk("frame_gap", n, 2 * CD0 + 1);
        wait_pix0(10, 1'b0, 3000);
        en[0] = 1'b0;
        wait_ev(0, 1'b1, 6000, n);
        chk("fd_count2", fd_cnt[0], 2);
        repeat (200) @(negedge clk);
        #1;
        chk("stay_idle_fb", fb_cnt[0], 2);
        chk("stay_idle_cs", 32'(cs_n[0]), 1);
        chk("stay_idle_busy", 32'(busy[0]), 0);

        // reset in the middle of a pixel shift
        en[0] = 1'b1;
        wait_ev(0, 1'b0, 10, n);
        wait_pix0(20, 1'b1, 3000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cs", 32'(cs_n[0]), 1);
        chk("rst_sclk", 32'(sclk[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_idx", 32'(pidx[0]), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ev(0, 1'b0, 10, n);
        chk("restart_latency", n, 1);
        chk("restart_idx", 32'(pidx[0]), 0);
        en[0] = 1'b0;
        wait_ev(0, 1'b1, 6000, n);
        chk("fd_count3", fd_cnt[0], 3);
        chk("fb_count4", fb_cnt[0], 4);

        // fast divider instance with constant red
        en[1] = 1'b1;
        wait_ev(1, 1'b0, 10, n);
        en[1] = 1'b0;
        wait_ev(1, 1'b1, 2000, n);
        repeat (20) @(negedge clk);
        #1;
        chk("d1_fd_count", fd_cnt[1], 1);
        chk("d1_fb_count", fb_cnt[1], 1);
        chk("d1_lit_word", 32'(last_word[1]), 32'hF800);
        chk("d1_rises", rises[1], 8 * 16 + 8 * NCMD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
